// File: rtl/if_else_emitter.sv
// if_else_emitter: serializes one "if(x<op><val>)begin p<=<c1>;endelsebegin p<=<c2>;end"
// statement into a 7-bit ASCII character stream with a valid/ready handshake.
//
// Ports:
//   clk, rst (async, active-high)
//   start                       - capture operands and emit one statement (IDLE only)
//   cmp_op[1:0]                 - 00 "==", 01 ">", 10 "<", 11 "!="
//   val_c, const1, const2       - unsigned VAL_W-bit operands
//   char_ready                  - downstream accepts ascii_char
//   ascii_char[6:0], char_valid - character stream
//   busy                        - statement in progress (through the done cycle)
//   done                        - one-cycle pulse after the last character
//
// Build option: define IF_ELSE_EMITTER_SPACE_EN to emit a space after each "begin".
module if_else_emitter #(
    parameter int VAL_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cmp_op,
    input  logic [VAL_W-1:0] val_c,
    input  logic [VAL_W-1:0] const1,
    input  logic [VAL_W-1:0] const2,
    input  logic             char_ready,
    output logic [6:0]       ascii_char,
    output logic             char_valid,
    output logic             busy,
    output logic             done
);
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(VAL_W + 1);
    localparam int MAXL = (DIGITS > 14) ? DIGITS : 14;
    localparam int IW   = $clog2(MAXL + 1);

`ifdef IF_ELSE_EMITTER_SPACE_EN
    localparam int SP = 1;
`else
    localparam int SP = 0;
`endif

    // Literal fragments, right-aligned. The "begin" fragments always
    // carry the trailing space; the field length decides if it is sent.
    localparam logic [111:0] S_IF   = {80'h0, "if(x"};
    localparam logic [111:0] S_BEG1 = {56'h0, ")begin "};
    localparam logic [111:0] S_BEG2 = ";endelsebegin ";
    localparam logic [111:0] S_P    = {88'h0, "p<="};
    localparam logic [111:0] S_END  = {80'h0, ";end"};

    typedef enum logic [1:0] {IDLE, CONV, EMIT, FIN} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [2:0][VAL_W-1:0]  bin_q, bin_d;
    logic [2:0][BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             fld_q, fld_d;
    logic [IW-1:0]          idx_q, idx_d;

    int          idx_i;
    int          flen;
    int          nd;
    int          vsel;
    logic [BW-1:0] vb;
    logic [3:0]  dg;
    logic [6:0]  ch;
    logic        last;

    function automatic logic [6:0] pick(logic [111:0] s, int len, int k);
        return s[8*(len-1-k) +: 7];
    endfunction

    // One shift-add-3 step: correct each digit, then shift in the next bit.
    function automatic logic [BW-1:0] dabble(logic [BW-1:0] b, logic in);
        logic [BW-1:0] t;
        t = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[4*d +: 4] >= 4'd5)
                t[4*d +: 4] = t[4*d +: 4] + 4'd3;
        end
        return {t[BW-2:0], in};
    endfunction

    // Significant digit count; zero still yields one digit.
    function automatic int ndig(logic [BW-1:0] b);
        int n;
        n = 1;
        for (int d = 1; d < DIGITS; d++) begin
            if (b[4*d +: 4] != 4'd0)
                n = d + 1;
        end
        return n;
    endfunction

    assign idx_i = int'(idx_q);

    // Character ROM: field + intra-field index select the current char.
    always_comb begin
        flen = 1;
        ch   = 7'h00;
        vsel = 0;
        vb   = '0;
        nd   = 1;
        dg   = 4'd0;
        unique case (fld_q)
            4'd0: begin
                flen = 4;
                ch   = pick(S_IF, 4, idx_i);
            end
            4'd1: begin
                flen = (op_q == 2'b01 || op_q == 2'b10) ? 1 : 2;
                if (idx_q != '0) begin
                    ch = 7'h3d;
                end else begin
                    unique case (op_q)
                        2'b00: ch = 7'h3d;
                        2'b01: ch = 7'h3e;
                        2'b10: ch = 7'h3c;
                        2'b11: ch = 7'h21;
                        default: ch = 7'h3d;
                    endcase
                end
            end
            4'd2, 4'd5, 4'd8: begin
                vsel = (fld_q == 4'd2) ? 0 : (fld_q == 4'd5) ? 1 : 2;
                vb   = bcd_q[vsel];
                nd   = ndig(vb);
                flen = nd;
                dg   = vb[4*(nd-1-idx_i) +: 4];
                ch   = {3'b011, dg};
            end
            4'd3: begin
                flen = 6 + SP;
                ch   = pick(S_BEG1, 7, idx_i);
            end
            4'd4, 4'd7: begin
                flen = 3;
                ch   = pick(S_P, 3, idx_i);
            end
            4'd6: begin
                flen = 13 + SP;
                ch   = pick(S_BEG2, 14, idx_i);
            end
            4'd9: begin
                flen = 4;
                ch   = pick(S_END, 4, idx_i);
            end
            default: begin
                flen = 1;
                ch   = 7'h00;
            end
        endcase
    end

    assign last = (idx_i == flen - 1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        fld_d      = fld_q;
        idx_d      = idx_q;
        char_valid = 1'b0;
        ascii_char = 7'h00;
        done       = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    op_d    = cmp_op;
                    bin_d   = {const2, const1, val_c};
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                for (int k = 0; k < 3; k++) begin
                    bcd_d[k] = dabble(bcd_q[k], bin_q[k][VAL_W-1]);
                    bin_d[k] = bin_q[k] << 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(VAL_W - 1)) begin
                    state_d = EMIT;
                    fld_d   = 4'd0;
                    idx_d   = '0;
                end
            end
            EMIT: begin
                char_valid = 1'b1;
                ascii_char = ch;
                if (char_ready) begin
                    if (last) begin
                        idx_d = '0;
                        if (fld_q == 4'd9)
                            state_d = FIN;
                        else
                            fld_d = fld_q + 4'd1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            fld_q   <= 4'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            fld_q   <= fld_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_if_else_emitter.sv
// tb_if_else_emitter: directed and randomized checks of the statement stream
// against a string-formatting reference model.
module tb_if_else_emitter;
    localparam int VAL_W = 16;
`ifdef IF_ELSE_EMITTER_SPACE_EN
    localparam bit SPACE = 1'b1;
    localparam int LEN_BASIC = 41;
`else
    localparam bit SPACE = 1'b0;
    localparam int LEN_BASIC = 39;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cmp_op = 2'b00;
    logic [15:0] val_c = '0;
    logic [15:0] const1 = '0;
    logic [15:0] const2 = '0;
    logic        char_ready = 1'b0;
    logic [6:0]  ascii_char;
    logic        char_valid;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    if_else_emitter #(.VAL_W(VAL_W), .DIGITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmp_op     (cmp_op),
        .val_c      (val_c),
        .const1     (const1),
        .const2     (const2),
        .char_ready (char_ready),
        .ascii_char (ascii_char),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic string model(input logic [1:0] op,
                                    input logic [15:0] v,
                                    input logic [15:0] a,
                                    input logic [15:0] b);
        string o;
        string sp;
        case (op)
            2'd0: o = "==";
            2'd1: o = ">";
            2'd2: o = "<";
            default: o = "!=";
        endcase
        sp = SPACE ? " " : "";
        return $sformatf("if(x%s%0d)begin%sp<=%0d;endelsebegin%sp<=%0d;end",
                         o, v, sp, a, sp, b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle. stall = percent of cycles with
    // char_ready low; abort_at > 0 resets after that many accepted chars;
    // poke pulses start mid-stream.
    task automatic emit(input logic [1:0] op, input logic [15:0] v,
                        input logic [15:0] a, input logic [15:0] b,
                        input int stall, input int abort_at, input bit poke,
                        output string got);
        string      exp;
        int         lat;
        int         cyc;
        bit         prev_stall;
        logic [6:0] held;
        exp = model(op, v, a, b);
        got = "";
        cmp_op = op;
        val_c = v;
        const1 = a;
        const2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cmp_op = 2'($urandom);
        val_c = 16'($urandom);
        const1 = 16'($urandom);
        const2 = 16'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!char_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("first_char_latency", lat, VAL_W);
        if (!char_valid)
            return;
        prev_stall = 1'b0;
        held = 7'h00;
        cyc = 0;
        while (got.len() < exp.len() && cyc < 4000) begin
            if (prev_stall)
                chk("stall_stable", 32'(ascii_char), 32'(held));
            chk("valid_mid_stream", 32'(char_valid), 32'd1);
            if (!char_valid)
                break;
            char_ready = ($urandom_range(99) >= stall);
            start = (poke && cyc == 5);
            held = ascii_char;
            prev_stall = !char_ready;
            if (char_ready)
                got = {got, $sformatf("%c", ascii_char)};
            @(posedge clk);
            #1;
            cyc++;
            if (abort_at > 0 && got.len() == abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_valid_low", 32'(char_valid), 32'd0);
                chk("rst_busy_low", 32'(busy), 32'd0);
                #2;
                rst = 1'b0;
                char_ready = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        start = 1'b0;
        char_ready = 1'b0;
        chk_s("stream", got, exp);
        chk("valid_after_last", 32'(char_valid), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        string s;
        string lit;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(char_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_char", 32'(ascii_char), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        emit(2'b01, 16'd5, 16'd20, 16'd30, 0, 0, 1'b0, s);
        chk("len_basic", s.len(), LEN_BASIC);
        lit = SPACE ? "if(x>5)begin p<=20;endelsebegin p<=30;end"
                    : "if(x>5)beginp<=20;endelsebeginp<=30;end";
        chk_s("literal_basic", s, lit);

        emit(2'b11, 16'd0, 16'd65535, 16'd7, 0, 0, 1'b0, s);
        lit = SPACE ? "if(x!=0)begin p<=65535;endelsebegin p<=7;end"
                    : "if(x!=0)beginp<=65535;endelsebeginp<=7;end";
        chk_s("literal_zero_max", s, lit);

        emit(2'b01, 16'd5, 16'd20, 16'd30, 50, 0, 1'b1, s);
        emit(2'b00, 16'd10, 16'd100, 16'd0, 30, 0, 1'b0, s);
        emit(2'b10, 16'd9999, 16'd10000, 16'd99, 0, 0, 1'b0, s);

        emit(2'b10, 16'd123, 16'd4, 16'd56, 30, 12, 1'b0, s);
        emit(2'b10, 16'd123, 16'd4, 16'd56, 0, 0, 1'b0, s);

        for (int i = 0; i < 20; i++) begin
            emit(2'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom_range(999)), int'($urandom_range(60)),
                 0, 1'b0, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
